// File: rtl/alu_seq_unit.sv
// Registered execute-stage ALU: NZCV status register, valid/ready input handshake
// and a shift-add multiplier that retires one multiplier bit per clock.
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       exe_cmd,
    input  logic             s_bit,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [3:0]       status
);

    localparam logic [3:0] CMD_MOV = 4'd1;
    localparam logic [3:0] CMD_ADD = 4'd2;
    localparam logic [3:0] CMD_ADC = 4'd3;
    localparam logic [3:0] CMD_SUB = 4'd4;
    localparam logic [3:0] CMD_SBC = 4'd5;
    localparam logic [3:0] CMD_AND = 4'd6;
    localparam logic [3:0] CMD_ORR = 4'd7;
    localparam logic [3:0] CMD_EOR = 4'd8;
    localparam logic [3:0] CMD_MVN = 4'd9;
    localparam logic [3:0] CMD_MUL = 4'd10;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             mul_s_r;

    logic             accept_s;
    logic [WIDTH-1:0] op2_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic             arith_s;
    logic             legal_s;
    logic [WIDTH-1:0] res_s;
    logic             n_s;
    logic             z_s;
    logic             v_s;
    logic [WIDTH-1:0] acc_next_s;

    assign in_ready = (state_r == IDLE);
    assign accept_s = in_valid && in_ready;

    // Second adder operand and carry-in; subtraction is in1 + ~in2 + cin (C=1 means no borrow).
    always_comb begin
        op2_s = in2;
        cin_s = 1'b0;
        case (exe_cmd)
            CMD_ADC: cin_s = status[1];
            CMD_SUB: begin
                op2_s = ~in2;
                cin_s = 1'b1;
            end
            CMD_SBC: begin
                op2_s = ~in2;
                cin_s = status[1];
            end
            default: begin
                op2_s = in2;
                cin_s = 1'b0;
            end
        endcase
    end

    assign sum_s = {1'b0, in1} + {1'b0, op2_s} + {{WIDTH{1'b0}}, cin_s};
    assign v_s   = (in1[WIDTH-1] == op2_s[WIDTH-1]) && (sum_s[WIDTH-1] != in1[WIDTH-1]);

    // Single-cycle result selection; illegal commands yield zero and never touch status.
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        arith_s = 1'b0;
        legal_s = 1'b1;
        case (exe_cmd)
            CMD_MOV: res_s = in2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                res_s   = sum_s[WIDTH-1:0];
                arith_s = 1'b1;
            end
            CMD_AND: res_s = in1 & in2;
            CMD_ORR: res_s = in1 | in2;
            CMD_EOR: res_s = in1 ^ in2;
            CMD_MVN: res_s = ~in2;
            CMD_MUL: res_s = {WIDTH{1'b0}};
            default: begin
                res_s   = {WIDTH{1'b0}};
                legal_s = 1'b0;
            end
        endcase
    end

    assign n_s = res_s[WIDTH-1];
    assign z_s = (res_s == {WIDTH{1'b0}});

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM, multiplier datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            mul_s_r   <= 1'b0;
            out       <= {WIDTH{1'b0}};
            out_valid <= 1'b0;
            status    <= 4'b0000;
        end else begin
            out_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (exe_cmd == CMD_MUL) begin
                            mcand_r  <= in1;
                            mplier_r <= in2;
                            acc_r    <= {WIDTH{1'b0}};
                            cnt_r    <= {CNT_W{1'b0}};
                            mul_s_r  <= s_bit;
                            state_r  <= MUL_RUN;
                        end else begin
                            out       <= res_s;
                            out_valid <= 1'b1;
                            if (s_bit && legal_s) begin
                                status <= {n_s, z_s,
                                           arith_s ? sum_s[WIDTH] : status[1],
                                           arith_s ? v_s : status[0]};
                            end
                        end
                    end
                end
                MUL_RUN: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_ITER) begin
                        out       <= acc_next_s;
                        out_valid <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= IDLE;
                        // Multiply only defines N and Z; C and V are left as they were.
                        if (mul_s_r) begin
                            status[3] <= acc_next_s[WIDTH-1];
                            status[2] <= (acc_next_s == {WIDTH{1'b0}});
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit (WIDTH = 32).
module tb_alu_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   exe_cmd;
    logic         s_bit;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] out;
    logic         out_valid;
    logic [3:0]   status;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [36:0] exp_v;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .s_bit(s_bit), .in1(in1), .in2(in2),
        .out(out), .out_valid(out_valid), .status(status)
    );

    task automatic drive(input logic [3:0] c, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        exe_cmd  = c;
        s_bit    = s;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; exe_cmd = 4'd0; s_bit = 1'b0; in1 = 32'd0; in2 = 32'd0;
        repeat (2) @(negedge clk);
        total_cnt++; if (out !== 32'd0) $display("FAIL reset_out: got %h want 00000000", out); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (status !== 4'b0000) $display("FAIL reset_status: got %b want 0000", status); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_add_overflow();
        drive(4'd2, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
        exp_v = {1'b1, 4'b1001, 32'h8000_0000};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL add_ovf: got %h want %h (valid,nzcv,out)", {out_valid, status, out}, exp_v); else pass_cnt++;
        @(posedge clk); #1;
        exp_v = {1'b0, 4'b1001, 32'h8000_0000};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL add_hold: got %h want %h (valid,nzcv,out)", {out_valid, status, out}, exp_v); else pass_cnt++;
    endtask

    task automatic test_logic_keep_cv();
        drive(4'd7, 1'b1, 32'h1, 32'h2);
        exp_v = {1'b1, 4'b0001, 32'h0000_0003};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL orr: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
        drive(4'd9, 1'b1, 32'h0, 32'h0);
        exp_v = {1'b1, 4'b1001, 32'hFFFF_FFFF};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL mvn: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
        drive(4'd8, 1'b1, 32'hFF, 32'hFF);
        exp_v = {1'b1, 4'b0101, 32'h0000_0000};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL eor: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
        drive(4'd1, 1'b1, 32'h1234, 32'h8000_0000);
        exp_v = {1'b1, 4'b1001, 32'h8000_0000};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL mov: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
    endtask

    task automatic test_sub_sbc();
        drive(4'd4, 1'b1, 32'd5, 32'd5);
        exp_v = {1'b1, 4'b0110, 32'h0};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL sub_eq: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
        drive(4'd5, 1'b1, 32'd3, 32'd1);
        exp_v = {1'b1, 4'b0010, 32'h2};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL sbc_c1: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
        drive(4'd2, 1'b1, 32'd0, 32'd0);
        exp_v = {1'b1, 4'b0100, 32'h0};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL add_zero: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
        drive(4'd5, 1'b1, 32'd0, 32'd0);
        exp_v = {1'b1, 4'b1000, 32'hFFFF_FFFF};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL sbc_c0: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
    endtask

    task automatic test_adc_and();
        drive(4'd4, 1'b1, 32'd5, 32'd5);
        drive(4'd3, 1'b1, 32'hFFFF_FFFF, 32'h0);
        exp_v = {1'b1, 4'b0110, 32'h0};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL adc: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
        drive(4'd6, 1'b1, 32'hF0, 32'h0F);
        exp_v = {1'b1, 4'b0110, 32'h0};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL and_keep_c: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
    endtask

    task automatic test_mul();
        int bad = 0;
        drive(4'd10, 1'b1, 32'd7, 32'hFFFF_FFFD);
        total_cnt++; if ({in_ready, out_valid} !== 2'b00) $display("FAIL mul_accept: got ready,valid=%b want 00", {in_ready, out_valid}); else pass_cnt++;
        for (int i = 1; i < W; i++) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            if (i == 3) begin
                exe_cmd = 4'd2; s_bit = 1'b1; in1 = 32'd1; in2 = 32'd1; in_valid = 1'b1;
            end
            if (i == 8) in_valid = 1'b0;
        end
        total_cnt++; if (bad !== 0) $display("FAIL mul_window: got %0d bad cycles want 0", bad); else pass_cnt++;
        @(posedge clk); #1;
        exp_v = {1'b1, 4'b1010, 32'hFFFF_FFEB};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL mul_done: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL mul_ready: got %b want 1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        exp_v = {1'b0, 4'b1010, 32'hFFFF_FFEB};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL mul_no_queue: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
    endtask

    task automatic test_sbit0_illegal();
        drive(4'd2, 1'b1, 32'h7FFF_FFFF, 32'h1);
        drive(4'd2, 1'b0, 32'd1, 32'd1);
        exp_v = {1'b1, 4'b1001, 32'h2};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL sbit0: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
        drive(4'd13, 1'b1, 32'd5, 32'd6);
        exp_v = {1'b1, 4'b1001, 32'h0};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL illegal: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
    endtask

    task automatic test_reset_mid_mul();
        int bad = 0;
        drive(4'd2, 1'b1, 32'h7FFF_FFFF, 32'h1);
        drive(4'd10, 1'b1, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        exp_v = {1'b0, 4'b0000, 32'h0};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL async_rst: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready); else pass_cnt++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL rst_no_pulse: got %0d pulses want 0", bad); else pass_cnt++;
        drive(4'd2, 1'b1, 32'd2, 32'd3);
        exp_v = {1'b1, 4'b0000, 32'h5};
        total_cnt++; if ({out_valid, status, out} !== exp_v) $display("FAIL post_rst_add: got %h want %h", {out_valid, status, out}, exp_v); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_logic_keep_cv();
        test_sub_sbc();
        test_adc_and();
        test_mul();
        test_sbit0_illegal();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
